// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: bus-mapped multiplexed 7-segment display controller.
// It holds a DATA word (one hex nibble per digit) and a CTRL register,
// and scans NUM_DIGITS digits with per-slot brightness PWM, a
// decimal-point mask, a blank mask and leading-zero suppression.
// The dig_en and seg outputs are active low and registered together,
// so both always change on the same clock edge.

module seg7_scan_ctrl #(
    parameter int          NUM_DIGITS = 8,
    parameter int          SCAN_DIV   = 20000,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_F000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic                  wen,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic [7:0]            seg
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] PHASE_DIV = CNT_W'(SCAN_DIV / 16);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [31:0]      CTRL_ADDR = BASE_ADDR + 32'd4;

    logic [31:0]           data_q;
    logic                  en_q;
    logic                  lzs_q;
    logic [7:0]            dp_q;
    logic [7:0]            blank_q;
    logic [3:0]            duty_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [NUM_DIGITS-1:0] suppressed;
    logic [CNT_W-1:0]      phase;
    logic [3:0]            nibble;
    logic                  lit;
    logic                  sel_data;
    logic                  sel_ctrl;

    // Active-low segment pattern {a,b,c,d,e,f,g} for one hex nibble.
    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'b0000001;
            4'h1: font = 7'b1001111;
            4'h2: font = 7'b0010010;
            4'h3: font = 7'b0000110;
            4'h4: font = 7'b1001100;
            4'h5: font = 7'b0100100;
            4'h6: font = 7'b0100000;
            4'h7: font = 7'b0001111;
            4'h8: font = 7'b0000000;
            4'h9: font = 7'b0000100;
            4'hA: font = 7'b0001000;
            4'hB: font = 7'b1100000;
            4'hC: font = 7'b0110001;
            4'hD: font = 7'b1000010;
            4'hE: font = 7'b0110000;
            default: font = 7'b0111000;
        endcase
    endfunction

    assign sel_data = (addr == BASE_ADDR);
    assign sel_ctrl = (addr == CTRL_ADDR);

    // Bus writes into DATA and CTRL; undefined CTRL bits are not stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= 32'h0;
            en_q    <= 1'b1;
            lzs_q   <= 1'b0;
            dp_q    <= 8'h00;
            blank_q <= 8'h00;
            duty_q  <= 4'hF;
        end else if (wen) begin
            if (sel_data) begin
                data_q <= wdata;
            end
            if (sel_ctrl) begin
                en_q    <= wdata[0];
                lzs_q   <= wdata[1];
                dp_q    <= wdata[15:8];
                blank_q <= wdata[23:16];
                duty_q  <= wdata[27:24];
            end
        end
    end

    // Combinational read-back, independent of wen.
    always_comb begin
        rdata = 32'h0;
        if (sel_data) begin
            rdata = data_q;
        end else if (sel_ctrl) begin
            rdata = {4'h0, duty_q, blank_q, dp_q, 6'b0, lzs_q, en_q};
        end
    end

    // Slot counter and digit index; both parked at 0 while disabled so a
    // re-enable starts with digit 0 and a full slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (!en_q) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Leading-zero suppression: walk down from the top digit while nibbles
    // stay zero; digit 0 is always shown.
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        suppressed = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (data_q[4*i +: 4] == 4'h0);
            suppressed[i] = lzs_q & zero_run;
        end
    end

    // Lit decision for the digit currently in its slot.
    always_comb begin
        phase  = cnt_q / PHASE_DIV;
        nibble = data_q[{idx_q, 2'b00} +: 4];
        lit    = en_q & (phase <= CNT_W'(duty_q)) & ~blank_q[idx_q] & ~suppressed[idx_q];
    end

    // Registered drive of digit enables and segments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_en <= '1;
            seg    <= 8'hFF;
        end else if (lit) begin
            dig_en <= ~(NUM_DIGITS'(1) << idx_q);
            seg    <= {font(nibble), ~dp_q[idx_q]};
        end else begin
            dig_en <= '1;
            seg    <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl with 4 digits and a 32-cycle slot.
module tb_seg7_scan_ctrl;

    localparam int          ND   = 4;
    localparam int          SD   = 32;
    localparam logic [31:0] BASE = 32'hFFFF_F000;
    localparam logic [31:0] CTRL_MASK = 32'h0FFF_FF03;

    logic          clk;
    logic          rst;
    logic [31:0]   addr;
    logic          wen;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [ND-1:0] dig_en;
    logic [7:0]    seg;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_on     = 0;

    logic [6:0] font_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic [31:0] m_data;
    logic [31:0] m_ctrl;
    int          ticks;
    logic [3:0]  exp_dig;
    logic [7:0]  exp_seg;

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wen(wen), .wdata(wdata),
        .rdata(rdata), .dig_en(dig_en), .seg(seg));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: "ticks" = cycles since the scan was last (re)started;
    // slot, position and brightness phase follow by plain arithmetic.
    task automatic predict(input logic [31:0] d, input logic [31:0] c, input int t,
                           output logic [3:0] pd, output logic [7:0] ps);
        int slot;
        int pos;
        logic [3:0] nib;
        bit supp;
        bit lit;
        slot = (t / SD) % ND;
        pos  = t % SD;
        nib  = d[slot*4 +: 4];
        supp = c[1] && (slot != 0) && ((d[15:0] >> (slot*4)) == 16'h0);
        lit  = c[0] && ((pos / (SD/16)) <= int'(c[27:24])) && !c[16+slot] && !supp;
        pd   = 4'hF;
        ps   = 8'hFF;
        if (lit) begin
            pd[slot] = 1'b0;
            ps = {font_tab[nib], ~c[8+slot]};
        end
    endtask

    always @(posedge clk or posedge rst) begin : model_blk
        logic [3:0] pd;
        logic [7:0] ps;
        if (rst) begin
            m_data  <= 32'h0;
            m_ctrl  <= 32'h0F00_0001;
            ticks   <= 0;
            exp_dig <= 4'hF;
            exp_seg <= 8'hFF;
        end else begin
            predict(m_data, m_ctrl, ticks, pd, ps);
            exp_dig <= pd;
            exp_seg <= ps;
            ticks   <= m_ctrl[0] ? ticks + 1 : 0;
            if (wen && addr == BASE)         m_data <= wdata;
            if (wen && addr == BASE + 32'd4) m_ctrl <= wdata & CTRL_MASK;
        end
    end

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            vectors++;
            if (dig_en !== exp_dig || seg !== exp_seg) begin
                miscompares++;
                $display("FAIL scan_model t=%0t dig_en=%b want %b seg=%b want %b",
                         $time, dig_en, exp_dig, seg, exp_seg);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        @(negedge clk);
        wen   = 1'b0;
        addr  = 32'h0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
        addr = 32'h0;
    endtask

    // Restart the scan: after return, the next negedge shows digit 0 at cnt 0.
    task automatic restart(input logic [31:0] ctrl);
        bus_write(BASE + 32'd4, ctrl & ~32'h1);
        bus_write(BASE + 32'd4, ctrl | 32'h1);
    endtask

    task automatic check_out(input string name, input logic [3:0] d, input logic [7:0] s);
        check({name, "_dig"}, {28'h0, dig_en}, {28'h0, d});
        check({name, "_seg"}, {24'h0, seg}, {24'h0, s});
    endtask

    typedef struct {
        logic        do_wr;
        logic [31:0] waddr;
        logic [31:0] wdat;
        logic [31:0] raddr;
        logic [31:0] exp;
    } bus_vec_t;

    initial begin
        bus_vec_t   tbl [8];
        logic [7:0] seg1234 [4];
        logic [3:0] ed;
        int         d;

        tbl[0] = '{1'b1, BASE,          32'hDEAD_BEEF, BASE,          32'hDEAD_BEEF};
        tbl[1] = '{1'b1, BASE + 32'd4,  32'hFFFF_FFFF, BASE + 32'd4,  32'h0FFF_FF03};
        tbl[2] = '{1'b1, BASE + 32'd4,  32'h1234_5678, BASE + 32'd4,  32'h0234_5600};
        tbl[3] = '{1'b0, BASE,          32'h0,         BASE + 32'd8,  32'h0};
        tbl[4] = '{1'b1, BASE + 32'd8,  32'hFFFF_FFFF, BASE,          32'hDEAD_BEEF};
        tbl[5] = '{1'b1, BASE - 32'd4,  32'h0,         BASE + 32'd4,  32'h0234_5600};
        tbl[6] = '{1'b1, BASE + 32'd4,  32'h0F00_0001, BASE + 32'd4,  32'h0F00_0001};
        tbl[7] = '{1'b0, BASE,          32'h0,         32'h0,         32'h0};
        seg1234[0] = 8'b1001100_1;
        seg1234[1] = 8'b0000110_1;
        seg1234[2] = 8'b0010010_1;
        seg1234[3] = 8'b1001111_1;

        rst = 1'b1; wen = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        read_check("rst_ctrl_init", BASE + 32'd4, 32'h0F00_0001);
        rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        check_out("first_after_rst", 4'b1110, 8'b0000001_1);

        // Register table
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].do_wr) bus_write(tbl[i].waddr, tbl[i].wdat);
            read_check($sformatf("bus_vec%0d", i), tbl[i].raddr, tbl[i].exp);
        end

        // Scan order with wrap
        bus_write(BASE, 32'h0000_1234);
        restart(32'h0F00_0001);
        for (int k = 0; k <= 128; k++) begin
            @(negedge clk);
            d  = (k / 32) % 4;
            ed = 4'hF;
            ed[d] = 1'b0;
            check_out($sformatf("scan_k%0d", k), ed, seg1234[d]);
        end

        // Mid-slot reset
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_out("rst_async", 4'hF, 8'hFF);
        read_check("rst_ctrl", BASE + 32'd4, 32'h0F00_0001);
        read_check("rst_data", BASE, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_out("rst_first_digit0", 4'b1110, 8'b0000001_1);

        // Leading-zero suppression
        bus_write(BASE, 32'h0000_0050);
        restart(32'h0F00_0003);
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            if (k == 0)  check_out("lzs_d0", 4'b1110, 8'b0000001_1);
            if (k == 32) check_out("lzs_d1", 4'b1101, 8'b0100100_1);
            if (k == 64) check_out("lzs_d2", 4'hF, 8'hFF);
            if (k == 96) check_out("lzs_d3", 4'hF, 8'hFF);
        end
        bus_write(BASE, 32'h0);
        restart(32'h0F00_0003);
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            if (k == 0)  check_out("lzs0_d0", 4'b1110, 8'b0000001_1);
            if (k == 32) check_out("lzs0_d1", 4'hF, 8'hFF);
            if (k == 96) check_out("lzs0_d3", 4'hF, 8'hFF);
        end

        // PWM duty 3 and 0
        bus_write(BASE, 32'h0000_1234);
        restart(32'h0300_0001);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            check_out($sformatf("duty3_k%0d", k), (k <= 7) ? 4'b1110 : 4'hF,
                      (k <= 7) ? seg1234[0] : 8'hFF);
        end
        restart(32'h0000_0001);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            check_out($sformatf("duty0_k%0d", k), (k <= 1) ? 4'b1110 : 4'hF,
                      (k <= 1) ? seg1234[0] : 8'hFF);
        end

        // DP and blank masks
        restart(32'h0F04_0201);
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            if (k == 3)  check_out("mask_d0", 4'b1110, 8'b1001100_1);
            if (k == 35) check_out("mask_d1", 4'b1101, 8'b0000110_0);
            if (k == 67) check_out("mask_d2", 4'hF, 8'hFF);
            if (k == 99) check_out("mask_d3", 4'b0111, 8'b1001111_1);
        end

        // Enable clear / set mid-slot
        restart(32'h0F00_0001);
        repeat (5) @(negedge clk);
        bus_write(BASE + 32'd4, 32'h0F00_0000);
        check_out("en_clr_write_edge", 4'b1110, seg1234[0]);
        @(negedge clk);
        check_out("en_clr_dark", 4'hF, 8'hFF);
        bus_write(BASE + 32'd4, 32'h0F00_0001);
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);
            if (k == 0)  check_out("en_set_d0", 4'b1110, seg1234[0]);
            if (k == 31) check_out("en_set_d0_end", 4'b1110, seg1234[0]);
            if (k == 32) check_out("en_set_d1", 4'b1101, seg1234[1]);
        end
        bus_write(BASE + 32'd8, 32'hFFFF_FFFF);
        read_check("bad_addr_rd", BASE + 32'd8, 32'h0);
        read_check("bad_addr_data", BASE, 32'h0000_1234);
        read_check("bad_addr_ctrl", BASE + 32'd4, 32'h0F00_0001);

        // Randomized traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                @(negedge clk);
            end else if (r < 82) begin
                bus_write(BASE, $urandom());
            end else if (r < 92) begin
                logic [31:0] c;
                c = $urandom();
                if ($urandom_range(0, 4) != 0) c[0] = 1'b1;
                bus_write(BASE + 32'd4, c);
            end else if (r < 95) begin
                bus_write(BASE + 32'd4 * $urandom_range(2, 5), $urandom());
            end else if (r < 99) begin
                case ($urandom_range(0, 2))
                    0: read_check("rand_rd_data", BASE, m_data);
                    1: read_check("rand_rd_ctrl", BASE + 32'd4, m_ctrl);
                    default: read_check("rand_rd_other", BASE + 32'd12, 32'h0);
                endcase
                @(negedge clk);
            end else begin
                @(negedge clk);
                #2 rst = 1'b1;
                #1;
                check_out("rand_rst", 4'hF, 8'hFF);
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
